// File: rtl/ahb_manager.sv
// ahb_manager: command-driven AHB-Lite manager (SINGLE / INCR4 / WRAP4 of 32-bit words).
// Latency: accept at edge T -> NONSEQ in T+1; zero-wait SINGLE cmd_done in T+3, INCR4 in T+6.
// Backpressure: cmd_ready only in IDLE; HREADY stalls both phases; late wd_valid gives IDLE (beat 0) or BUSY.
// Ports: cmd_* command request, wd_* write beats in, rd_* read beats out (no backpressure),
//        cmd_done/cmd_err completion status, H* AHB-Lite manager bus towards the interconnect.
// Option: define AHB_MANAGER_ERR_ABORT_EN to drop the remaining beats after an ERROR response;
//         when undefined the burst runs to completion and the error is reported at the end.
module ahb_manager #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_burst,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  cmd_done,
    output logic                  cmd_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic [1:0]            HRESP,
    input  logic                  HREADY
);

`ifdef AHB_MANAGER_ERR_ABORT_EN
    localparam logic ERR_ABORT = 1'b1;
`else
    localparam logic ERR_ABORT = 1'b0;
`endif

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_LAST, ST_ERR} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic                    write_q;
    logic [1:0]              burst_q;       // 0 SINGLE, 1 INCR4, 2 WRAP4
    logic [1:0]              beat_q;        // index of the beat whose address is presented
    logic                    dp_vld_q;      // a data phase is in progress this cycle
    logic                    dp_write_q;
    logic                    err_q;         // sticky ERROR seen during this command
    logic                    err_issuing_q; // ERROR arrived while beats were still being issued
    logic                    done_d;
    logic                    err_now;
    logic                    issuing;
    logic                    addr_go;
    logic [1:0]              last_beat;
    logic [1:0]              wrap_idx;
    logic [1:0]              htrans_c;

    assign last_beat = (burst_q == 2'd0) ? 2'd0 : 2'd3;
    // First cycle of the two-cycle ERROR response for the beat in its data phase.
    assign err_now   = dp_vld_q && (HRESP == 2'b01) && !HREADY &&
                       ((state_q == ST_ADDR) || (state_q == ST_LAST));
    // Without abort, the ERR cycle keeps presenting the pending address like ADDR does.
    assign issuing   = (state_q == ST_ADDR) ||
                       (!ERR_ABORT && (state_q == ST_ERR) && err_issuing_q);

    always_comb begin
        htrans_c = TR_IDLE;
        if (issuing) begin
            if (write_q && !wd_valid) begin
                htrans_c = (beat_q == 2'd0) ? TR_IDLE : TR_BUSY;
            end else begin
                htrans_c = (beat_q == 2'd0) ? TR_NONSEQ : TR_SEQ;
            end
        end
        if (ERR_ABORT && err_now) begin
            htrans_c = TR_IDLE;
        end
    end

    assign addr_go   = htrans_c[1] && HREADY;
    assign HTRANS    = htrans_c;
    assign wd_ready  = addr_go && write_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign HWRITE    = write_q;
    assign HSIZE     = 3'b010;
    assign HPROT     = 4'b0011;

    // WRAP4 keeps [ADDR_WIDTH-1:4] and wraps the word index; INCR4/SINGLE add 4 per beat.
    assign wrap_idx = base_q[3:2] + beat_q;
    always_comb begin
        if (burst_q == 2'd2) begin
            HADDR = {base_q[ADDR_WIDTH-1:4], wrap_idx, 2'b00};
        end else begin
            HADDR = base_q + {{(ADDR_WIDTH-4){1'b0}}, beat_q, 2'b00};
        end
    end

    always_comb begin
        case (burst_q)
            2'd1:    HBURST = 3'b011;
            2'd2:    HBURST = 3'b010;
            default: HBURST = 3'b000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (err_now) begin
                    state_d = ST_ERR;
                end else if (addr_go && (beat_q == last_beat)) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                if (err_now) begin
                    state_d = ST_ERR;
                end else if (HREADY) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    if (ERR_ABORT || !err_issuing_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (addr_go && (beat_q == last_beat)) begin
                        state_d = ST_LAST;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            base_q        <= '0;
            write_q       <= 1'b0;
            burst_q       <= 2'd0;
            beat_q        <= 2'd0;
            dp_vld_q      <= 1'b0;
            dp_write_q    <= 1'b0;
            err_q         <= 1'b0;
            err_issuing_q <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            cmd_done      <= 1'b0;
            cmd_err       <= 1'b0;
            HWDATA        <= '0;
        end else begin
            if ((state_q == ST_IDLE) && cmd_valid) begin
                base_q  <= cmd_addr;
                write_q <= cmd_write;
                burst_q <= (cmd_burst == 2'd3) ? 2'd0 : cmd_burst;
                beat_q  <= 2'd0;
                err_q   <= 1'b0;
            end else if (addr_go) begin
                beat_q <= beat_q + 2'd1;
            end
            if (HREADY) begin
                dp_vld_q   <= addr_go;
                dp_write_q <= write_q;
            end
            if (err_now) begin
                err_q         <= 1'b1;
                err_issuing_q <= (state_q == ST_ADDR);
            end
            // Aborted commands never return the errored read beat.
            rd_valid <= dp_vld_q && !dp_write_q && HREADY && !(ERR_ABORT && (state_q == ST_ERR));
            if (dp_vld_q && !dp_write_q && HREADY) begin
                rd_data <= HRDATA;
            end
            if (wd_ready) begin
                HWDATA <= wd_data;
            end
            cmd_done <= done_d;
            cmd_err  <= done_d && err_q;
        end
    end

endmodule

// File: doc/ahb_manager.md
# ahb_manager

Command-driven AHB-Lite manager that sits directly upstream of the `ahb_lite` interconnect. It drives HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA and consumes HRDATA/HRESP/HREADY. It converts single-command requests (SINGLE, INCR4, WRAP4 of 32-bit words) into pipelined address and data phases. It honours wait states, inserts BUSY when write data is late, and returns read data and completion status to the local client.

## Interface
- ADDR_WIDTH, 32, HADDR and cmd_addr width
- DATA_WIDTH, 32, HWDATA/HRDATA/wd_data/rd_data width
- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  reset; **one clock; reset is asynchronous and active-low**
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE; command accepted on cmd_valid&&cmd_ready
- cmd_addr  in  ADDR_WIDTH  start byte address, [1:0] must be 0
- cmd_write  in  1  1 = write, 0 = read
- cmd_burst  in  2  0 = SINGLE, 1 = INCR4, 2 = WRAP4, 3 = treated as SINGLE
- wd_valid / wd_ready  in / out  1 / 1  per-beat write data handshake
- wd_data  in  DATA_WIDTH  write beat data
- rd_valid  out  1  one-cycle pulse per completed read beat (no backpressure)
- rd_data  out  DATA_WIDTH  registered HRDATA
- cmd_done  out  1  one-cycle pulse when the command finishes
- cmd_err  out  1  valid with cmd_done; 1 if any beat got ERROR
- HADDR, HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HWDATA  out  AHB manager signals
- HRDATA, HRESP[1:0], HREADY  in  from interconnect; HRESP 2'b00 = OKAY, 2'b01 = ERROR

## Operation
- States: IDLE, ADDR (issuing beats), LAST (data phase of the final beat only), ERR (second ERROR cycle).
- IDLE: HTRANS = IDLE(00) and cmd_ready = 1. On accept, latch the command, set the beat counter to 0, and go to ADDR.
- Fixed fields: HSIZE = 3'b010. HPROT = 4'b0011. HBURST = 000 for SINGLE, 011 for INCR4, 010 for WRAP4.
- Address generation:
  - Beat 0 = cmd_addr.
  - INCR4: +4 per beat.
  - WRAP4: upper bits [ADDR_WIDTH-1:4] held; [3:2] increments modulo 4.
- HTRANS:
  - Beat 0 = NONSEQ(10); later beats = SEQ(11).
  - For writes, a beat is issued only when wd_valid = 1.
  - If wd_valid = 0 mid-burst, drive BUSY(01) with HADDR holding the next beat address.
  - If wd_valid = 0 at beat 0, stay IDLE(00) in ADDR.
- wd_ready = 1 when a write beat's address phase is presented and HREADY = 1. wd_data is registered onto HWDATA for that beat's data phase.
- Address/control advance only on HREADY = 1. After the final beat's address is accepted, go to LAST and drive HTRANS = IDLE.
- Reads: on HREADY = 1 in a read data phase, the next cycle asserts rd_valid with rd_data = HRDATA.
- Completion: when the final data phase ends with HREADY = 1, the next cycle pulses cmd_done (cmd_err = sticky error flag) and the state returns to IDLE.
- ERROR: HRESP = ERROR with HREADY = 0 → set the sticky error flag and go to ERR. The second cycle (HREADY = 1) completes the beat. Behaviour beyond that is set by the configuration macro.
- HRESP values 2'b10 and 2'b11 are treated as OKAY.

## Timing
- Reset values:
  - State = IDLE, HTRANS = 00, HADDR = 0, HWRITE = 0, HBURST = 0, HWDATA = 0.
  - HSIZE = 3'b010, HPROT = 4'b0011.
  - rd_valid = 0, rd_data = 0, cmd_done = 0, cmd_err = 0, wd_ready = 0.
  - cmd_ready = 1 (decoded from state); commands are ignored while HRESETn = 0.
- Accept at edge T → NONSEQ visible in cycle T+1.
- SINGLE with zero waits:
  - T+1 address phase, T+2 data phase.
  - rd_valid/cmd_done in T+3; cmd_ready = 1 in T+3.
- Zero-wait INCR4: four consecutive address cycles, cmd_done 6 cycles after accept.
- Reset asserted mid-burst: all outputs go to reset values immediately. No cmd_done is issued for the aborted command.
- A new command is never accepted in the cycle cmd_done pulses' predecessor; cmd_done and cmd_ready are both high in the same cycle.

## Configuration
- AHB_MANAGER_ERR_ABORT_EN defined:
  - In the first ERROR cycle, the manager drives HTRANS = IDLE.
  - Remaining beats are dropped and no further wd_ready/rd_valid occur.
  - cmd_done, with cmd_err = 1, pulses the cycle after the second ERROR cycle.
- Undefined:
  - The burst continues with the remaining beats.
  - cmd_err = 1 is reported at normal completion.

## Test plan
- SINGLE write 0x0000_0010, wd_data 0xDEADBEEF, no waits → NONSEQ at T+1, HWDATA = 0xDEADBEEF at T+2, cmd_done at T+3 with cmd_err = 0.
- INCR4 read at 0x20, HREADY low 2 cycles during beat 1's data phase → HADDR 0x20/0x24/0x28/0x2C held correctly, 4 rd_valid pulses in order, cmd_done with cmd_err = 0.
- WRAP4 read at 0x38 → HADDR 0x38, 0x3C, 0x30, 0x34; HBURST = 010.
- INCR4 write with wd_valid low for 2 cycles before beat 2 → HTRANS = BUSY for 2 cycles at HADDR 0x...8, then SEQ; all four HWDATA values correct.
- INCR4 read, ERROR on beat 1:
  - With AHB_MANAGER_ERR_ABORT_EN: HTRANS = IDLE in the first ERROR cycle, 1 rd_valid only, cmd_done with cmd_err = 1.
  - Without it: 4 rd_valid pulses, then cmd_err = 1.
- HRESETn low during beat 2 of an INCR4 → HTRANS = 00 and cmd_done = 0 immediately; after release, a SINGLE command completes normally.
